// File: rtl/div4_pkg.sv
// Shared types and constants for the 4-bit sequential divide path.
package div4_pkg;

   localparam int unsigned DIV_W = 4;
   localparam int unsigned STEP_LAST = 0;
   localparam logic [DIV_W-1:0] DZ_QUOTIENT = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div4_seq_ctrl_add_sub.sv
// 4-bit add/sub datapath: z = x + y or x - y; carry_out is "no borrow" when subtracting.
module add_sub_4bit
   import div4_pkg::*;
(
   input  logic [DIV_W-1:0] x,
   input  logic [DIV_W-1:0] y,
   input  logic             add_sub_select,
   output logic [DIV_W-1:0] z,
   output logic             carry_out
);

   logic [DIV_W-1:0] y_eff;
   logic [DIV_W:0]   sum;

   always_comb begin
      y_eff     = y ^ {DIV_W{add_sub_select}};
      sum       = {1'b0, x} + {1'b0, y_eff} + {{DIV_W{1'b0}}, add_sub_select};
      z         = sum[DIV_W-1:0];
      carry_out = sum[DIV_W];
   end

endmodule

// File: rtl/div4_seq_ctrl.sv
// Restoring 4-bit unsigned divider: one trial subtraction per cycle through a shared add/sub unit.
module div4_seq_ctrl
   import div4_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             div_by_zero
);

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] n_q;
   logic [DIV_W-1:0] d_q;
   logic [DIV_W-1:0] r_q;
   logic [DIV_W-1:0] q_q;
   logic [1:0]       step_q;

   logic [DIV_W-1:0] trial;
   logic [DIV_W-1:0] diff;
   logic             no_borrow;
   logic [DIV_W-1:0] r_next;
   logic [DIV_W-1:0] q_next;
   logic             last_step;

   // Partial remainder never exceeds 15, so the 4-bit carry alone decides each bit.
   assign trial = {r_q[DIV_W-2:0], n_q[step_q]};

   add_sub_4bit u_add_sub (
      .x              (trial),
      .y              (d_q),
      .add_sub_select (1'b1),
      .z              (diff),
      .carry_out      (no_borrow)
   );

   always_comb begin
      r_next         = no_borrow ? diff : trial;
      q_next         = q_q;
      q_next[step_q] = no_borrow;
      last_step      = (step_q == 2'(STEP_LAST));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (divisor == '0) ? DONE : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (last_step) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q         <= '0;
         d_q         <= '0;
         r_q         <= '0;
         q_q         <= '0;
         step_q      <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  n_q         <= dividend;
                  d_q         <= divisor;
                  r_q         <= '0;
                  q_q         <= '0;
                  step_q      <= 2'd3;
                  div_by_zero <= (divisor == '0);
                  // Divide-by-zero completes straight from acceptance.
                  if (divisor == '0) begin
                     quotient  <= DZ_QUOTIENT;
                     remainder <= dividend;
                  end
               end
            end
            RUN: begin
               r_q <= r_next;
               q_q <= q_next;
               if (last_step) begin
                  quotient  <= q_next;
                  remainder <= r_next;
               end else begin
                  step_q <= step_q - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
